// File: rtl/bus_cycle_ctrl_if.sv
// ---------------------------------------------------------------------------
// bus_cycle_ctrl_if
// CPU bus cycle signals between the CPU pins and bus_cycle_ctrl.
//   addr        CPU address, longword granular (bits [1:0] are don't-care)
//   dmac_n      SDMAC chip select, active low
//   as_n        CPU address strobe, active low
//   rw          1 = read, 0 = write
//   dmadir      CONTR direction bit, 0 = SCSI->memory
//   dsack_n     cycle acknowledge, active low
//   contr_rd_n  CONTR read select, active low (level)
//   contr_wr    CONTR write select (level)
//   istr_rd_n   ISTR read select, active low (level)
//   wtc_rd_n    WTC read select, active low (level)
//   acr_wr      ACR write select (level)
//   wdregreq    WD33C93 register access in progress (level)
//   st_dma      start-DMA strobe (1-cycle pulse)
//   sp_dma      stop-DMA strobe (1-cycle pulse)
//   clr_int     clear-interrupt strobe (1-cycle pulse)
//   flush_n     FIFO flush strobe, active low (1-cycle pulse)
// master = CPU side, slave = bus_cycle_ctrl.
// ---------------------------------------------------------------------------
interface bus_cycle_ctrl_if #(
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] addr;
    logic              dmac_n;
    logic              as_n;
    logic              rw;
    logic              dmadir;
    logic              dsack_n;
    logic              contr_rd_n;
    logic              contr_wr;
    logic              istr_rd_n;
    logic              wtc_rd_n;
    logic              acr_wr;
    logic              wdregreq;
    logic              st_dma;
    logic              sp_dma;
    logic              clr_int;
    logic              flush_n;

    modport master (
        output addr, dmac_n, as_n, rw, dmadir,
        input  dsack_n, contr_rd_n, contr_wr, istr_rd_n, wtc_rd_n, acr_wr,
               wdregreq, st_dma, sp_dma, clr_int, flush_n
    );

    modport slave (
        input  addr, dmac_n, as_n, rw, dmadir,
        output dsack_n, contr_rd_n, contr_wr, istr_rd_n, wtc_rd_n, acr_wr,
               wdregreq, st_dma, sp_dma, clr_int, flush_n
    );
endinterface

// File: rtl/bus_cycle_ctrl.sv
// ---------------------------------------------------------------------------
// bus_cycle_ctrl
// Synchronises the CPU bus cycle (as_n & dmac_n) into i_sclk, decodes the
// SDMAC / WD33C93 register map on the latched address, inserts wait states,
// drives dsack_n, holds level selects for the access and fires the command
// strobes once per bus cycle on ACK entry.
// Ports:
//   i_sclk   system clock, rising edge
//   i_rst_n  asynchronous active-low reset
//   io_bus   bus_cycle_ctrl_if.slave (CPU bus inputs, selects/strobes out)
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | no access; waiting for synchronised cycle request
// DECODE | one cycle; selects valid, wait counter loaded
// WAIT   | counting down wait states
// ACK    | dsack_n low until the CPU ends the cycle
// ---------------------------------------------------------------------------
module bus_cycle_ctrl #(
    parameter int ADDR_W      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int NUM_WAIT    = 2,
    parameter int WD_WAIT     = 4
) (
    input  logic              i_sclk,
    input  logic              i_rst_n,
    bus_cycle_ctrl_if.slave   io_bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DECODE = 2'd1,
        S_WAIT   = 2'd2,
        S_ACK    = 2'd3
    } state_t;

    localparam logic [3:0] C_NUM_WAIT = 4'(NUM_WAIT);
    localparam logic [3:0] C_WD_WAIT  = 4'(WD_WAIT);

    state_t                   r_state;
    state_t                   w_next;
    logic [SYNC_STAGES-1:0]   r_sync;
    logic                     w_cyc;
    logic [ADDR_W-1:2]        r_addr;
    logic                     r_rw;
    logic                     r_dir;
    logic [3:0]               r_wait_cnt;
    logic                     w_wait_tc;
    logic                     w_enter_ack;
    logic                     r_st_dma;
    logic                     r_sp_dma;
    logic                     r_clr_int;
    logic                     r_flush;
    logic                     w_addr_unused;

    logic                     w_upper_zero;
    logic [5:0]               w_off;
    logic                     w_hit_wtc;
    logic                     w_hit_contr_rd;
    logic                     w_hit_contr_wr;
    logic                     w_hit_acr;
    logic                     w_hit_st;
    logic                     w_hit_flush;
    logic                     w_hit_clr;
    logic                     w_hit_istr;
    logic                     w_hit_sp;
    logic                     w_hit_wd;

    logic                     w_dsack_n;
    logic                     w_contr_rd_n;
    logic                     w_contr_wr;
    logic                     w_istr_rd_n;
    logic                     w_wtc_rd_n;
    logic                     w_acr_wr;
    logic                     w_wdregreq;

    // Address is longword granular; the byte bits never take part in decode.
    assign w_addr_unused = ^io_bus.addr[1:0];

    // Synchroniser idles high (no cycle) so reset looks like an idle bus.
    always_ff @(posedge i_sclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], io_bus.as_n | io_bus.dmac_n};
        end
    end

    assign w_cyc = ~r_sync[SYNC_STAGES-1];

    // ---------------- decode of latched cycle attributes ----------------
    generate
        if (ADDR_W > 8) begin : g_upper
            assign w_upper_zero = (r_addr[ADDR_W-1:8] == '0);
        end else begin : g_no_upper
            assign w_upper_zero = 1'b1;
        end
    endgenerate

    assign w_off          = r_addr[7:2];
    assign w_hit_wtc      = w_upper_zero && (w_off == 6'h01) &&  r_rw;
    assign w_hit_contr_rd = w_upper_zero && (w_off == 6'h02) &&  r_rw;
    assign w_hit_contr_wr = w_upper_zero && (w_off == 6'h02) && !r_rw;
    assign w_hit_acr      = w_upper_zero && (w_off == 6'h03) && !r_rw;
    assign w_hit_st       = w_upper_zero && (w_off == 6'h04);
    assign w_hit_flush    = w_upper_zero && (w_off == 6'h05) && !r_dir;
    assign w_hit_clr      = w_upper_zero && (w_off == 6'h06);
    assign w_hit_istr     = w_upper_zero && (w_off == 6'h07) &&  r_rw;
    assign w_hit_sp       = w_upper_zero && (w_off == 6'h0F);
    // 0x40-0x5C: offsets 0x10-0x17
    assign w_hit_wd       = w_upper_zero && (w_off[5:3] == 3'b010);

    // Leaving WAIT at count 1 puts ACK W edges after DECODE; a count
    // loaded as 0 still spends exactly one cycle in WAIT.
    assign w_wait_tc   = (r_wait_cnt <= 4'd1);
    assign w_enter_ack = (r_state == S_WAIT) && (w_next == S_ACK);

    // ---------------- state register, latches, wait counter -------------
    always_ff @(posedge i_sclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_rw       <= 1'b0;
            r_dir      <= 1'b0;
            r_wait_cnt <= 4'd0;
        end else begin
            r_state <= w_next;
            if ((r_state == S_IDLE) && w_cyc) begin
                r_addr <= io_bus.addr[ADDR_W-1:2];
                r_rw   <= io_bus.rw;
                r_dir  <= io_bus.dmadir;
            end
            if (r_state == S_DECODE) begin
                r_wait_cnt <= w_hit_wd ? C_WD_WAIT : C_NUM_WAIT;
            end else if ((r_state == S_WAIT) && (r_wait_cnt != 4'd0)) begin
                r_wait_cnt <= r_wait_cnt - 4'd1;
            end
        end
    end

    // ---------------- next state ----------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_cyc) w_next = S_DECODE;
            S_DECODE: w_next = w_cyc ? S_WAIT : S_IDLE;
            S_WAIT: begin
                if (!w_cyc)         w_next = S_IDLE;
                else if (w_wait_tc) w_next = S_ACK;
            end
            S_ACK:    if (!w_cyc) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Strobes are registered off the WAIT->ACK transition, which happens
    // once per bus cycle, so a long-held AS_ cannot retrigger them.
    always_ff @(posedge i_sclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_st_dma  <= 1'b0;
            r_sp_dma  <= 1'b0;
            r_clr_int <= 1'b0;
            r_flush   <= 1'b0;
        end else begin
            r_st_dma  <= w_enter_ack && w_hit_st;
            r_sp_dma  <= w_enter_ack && w_hit_sp;
            r_clr_int <= w_enter_ack && w_hit_clr;
            r_flush   <= w_enter_ack && w_hit_flush;
        end
    end

    // ---------------- outputs -------------------------------------------
    always_comb begin
        w_dsack_n    = 1'b1;
        w_contr_rd_n = 1'b1;
        w_contr_wr   = 1'b0;
        w_istr_rd_n  = 1'b1;
        w_wtc_rd_n   = 1'b1;
        w_acr_wr     = 1'b0;
        w_wdregreq   = 1'b0;
        if (r_state != S_IDLE) begin
            w_contr_rd_n = ~w_hit_contr_rd;
            w_contr_wr   =  w_hit_contr_wr;
            w_istr_rd_n  = ~w_hit_istr;
            w_wtc_rd_n   = ~w_hit_wtc;
            w_acr_wr     =  w_hit_acr;
            w_wdregreq   =  w_hit_wd;
        end
        if (r_state == S_ACK) begin
            w_dsack_n = 1'b0;
        end
    end

    assign io_bus.dsack_n    = w_dsack_n;
    assign io_bus.contr_rd_n = w_contr_rd_n;
    assign io_bus.contr_wr   = w_contr_wr;
    assign io_bus.istr_rd_n  = w_istr_rd_n;
    assign io_bus.wtc_rd_n   = w_wtc_rd_n;
    assign io_bus.acr_wr     = w_acr_wr;
    assign io_bus.wdregreq   = w_wdregreq;
    assign io_bus.st_dma     = r_st_dma;
    assign io_bus.sp_dma     = r_sp_dma;
    assign io_bus.clr_int    = r_clr_int;
    assign io_bus.flush_n    = ~r_flush;

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bus_cycle_ctrl
// Directed vector table, address-map sweep with ADDR_W=12, and hand-written
// abort / reset-in-ACK sequences. Expected cycle results are queued when a
// cycle is driven and popped when the DUT acknowledges it.
// ---------------------------------------------------------------------------
module tb_bus_cycle_ctrl;

    localparam int AW = 12;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    bus_cycle_ctrl_if #(.ADDR_W(AW)) bif ();

    bus_cycle_ctrl #(.ADDR_W(AW)) dut (
        .i_sclk  (clk),
        .i_rst_n (rst_n),
        .io_bus  (bif.slave)
    );

    // sel bits: [5]contr_rd [4]contr_wr [3]istr_rd [2]wtc_rd [1]acr_wr [0]wdregreq
    // pul bits: [3]st_dma [2]sp_dma [1]clr_int [0]flush
    typedef struct {
        logic [11:0] addr;
        logic        rw;
        logic        dir;
        int          hold;
        bit          scramble;
        logic [5:0]  sel;
        logic [3:0]  pul;
        int          lat;
    } vec_t;

    localparam logic [10:0] IDLE_OUT = 11'b11111_000000;

    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t sb[$];
    vec_t tbl[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    function automatic logic [5:0] get_sel();
        return {~bif.contr_rd_n, bif.contr_wr, ~bif.istr_rd_n, ~bif.wtc_rd_n,
                bif.acr_wr, bif.wdregreq};
    endfunction

    function automatic logic [3:0] get_pul();
        return {bif.st_dma, bif.sp_dma, bif.clr_int, ~bif.flush_n};
    endfunction

    function automatic logic [10:0] get_all();
        return {bif.dsack_n, bif.contr_rd_n, bif.istr_rd_n, bif.wtc_rd_n, bif.flush_n,
                bif.contr_wr, bif.acr_wr, bif.wdregreq, bif.st_dma, bif.sp_dma, bif.clr_int};
    endfunction

    function automatic vec_t mk(input logic [11:0] a, input logic rw, input logic dir,
                                input int hold, input bit scr, input logic [5:0] sel,
                                input logic [3:0] pul, input int lat);
        vec_t v;
        v.addr = a; v.rw = rw; v.dir = dir; v.hold = hold; v.scramble = scr;
        v.sel = sel; v.pul = pul; v.lat = lat;
        return v;
    endfunction

    // Reference register map, written from the address table.
    function automatic vec_t model(input logic [11:0] a, input logic rw, input logic dir);
        vec_t       v;
        logic [7:0] off;
        v = mk(a, rw, dir, 0, 1'b0, 6'b0, 4'b0, 5);
        off = a[7:0] & 8'hFC;
        if (a[11:8] == 4'h0) begin
            case (off)
                8'h04: if (rw)  v.sel = 6'b000100;
                8'h08: v.sel = rw ? 6'b100000 : 6'b010000;
                8'h0C: if (!rw) v.sel = 6'b000010;
                8'h10: v.pul = 4'b1000;
                8'h14: if (!dir) v.pul = 4'b0001;
                8'h18: v.pul = 4'b0010;
                8'h1C: if (rw)  v.sel = 6'b001000;
                8'h3C: v.pul = 4'b0100;
                default: begin
                    if (off >= 8'h40 && off <= 8'h5C) begin
                        v.sel = 6'b000001;
                        v.lat = 7;
                    end
                end
            endcase
        end
        return v;
    endfunction

    function automatic logic [7:0] pack_cnt(input int c3, input int c2, input int c1, input int c0);
        logic [1:0] s[4];
        int c[4];
        c[3] = c3; c[2] = c2; c[1] = c1; c[0] = c0;
        for (int b = 0; b < 4; b++) s[b] = (c[b] > 3) ? 2'd3 : 2'(c[b]);
        return {s[3], s[2], s[1], s[0]};
    endfunction

    task automatic run_cycle(input vec_t v, input string tag);
        vec_t       e;
        int         cnt[4];
        bit         got;
        int         rel;
        logic [3:0] p;
        cnt = '{default: 0};
        got = 1'b0;
        rel = -1;
        @(negedge clk);
        bif.addr   = v.addr;
        bif.rw     = v.rw;
        bif.dmadir = v.dir;
        bif.as_n   = 1'b0;
        bif.dmac_n = 1'b0;
        sb.push_back(v);
        // i = number of rising edges after the first one sampling the cycle
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            p = get_pul();
            for (int b = 0; b < 4; b++) if (p[b]) cnt[b]++;
            if (i == 1) check({tag, " sel_early"}, 32'(get_sel()), 32'd0);
            if (i == 2) check({tag, " sel"}, 32'(get_sel()), 32'(v.sel));
            if (v.scramble && i == 3) bif.addr = v.addr ^ 12'h0FC;
            if (bif.dsack_n == 1'b0) begin
                got = 1'b1;
                e = sb.pop_front();
                check({tag, " ack_lat"}, 32'(i), 32'(e.lat));
                check({tag, " pulse_at_ack"}, 32'(p), 32'(e.pul));
                break;
            end
        end
        if (!got) begin
            timeout_fail({tag, " ack"});
            e = sb.pop_front();
        end
        repeat (v.hold) begin
            @(negedge clk);
            p = get_pul();
            for (int b = 0; b < 4; b++) if (p[b]) cnt[b]++;
        end
        bif.as_n   = 1'b1;
        bif.dmac_n = 1'b1;
        for (int r = 0; r < 10; r++) begin
            @(negedge clk);
            p = get_pul();
            for (int b = 0; b < 4; b++) if (p[b]) cnt[b]++;
            if (r == 1 && got) check({tag, " held"}, 32'({bif.dsack_n, get_sel()}), 32'({1'b0, e.sel}));
            if (bif.dsack_n == 1'b1) begin
                rel = r;
                check({tag, " release_out"}, 32'(get_all()), 32'(IDLE_OUT));
                break;
            end
        end
        if (got) check({tag, " release_lat"}, 32'(rel), 32'd2);
        check({tag, " pulse_count"}, 32'(pack_cnt(cnt[3], cnt[2], cnt[1], cnt[0])),
              32'({1'b0, e.pul[3], 1'b0, e.pul[2], 1'b0, e.pul[1], 1'b0, e.pul[0]}));
    endtask

    task automatic abort_cycle(input logic [11:0] a, input logic rw, input int rel_at, input string tag);
        int acks;
        int puls;
        acks = 0;
        puls = 0;
        @(negedge clk);
        bif.addr   = a;
        bif.rw     = rw;
        bif.dmadir = 1'b0;
        bif.as_n   = 1'b0;
        bif.dmac_n = 1'b0;
        for (int i = 0; i < rel_at + 20; i++) begin
            @(negedge clk);
            if (bif.dsack_n == 1'b0) acks++;
            if (get_pul() != 4'b0) puls++;
            if (i == rel_at) begin
                bif.as_n   = 1'b1;
                bif.dmac_n = 1'b1;
            end
        end
        check({tag, " abort_acks"}, 32'(acks), 32'd0);
        check({tag, " abort_pulses"}, 32'(puls), 32'd0);
        check({tag, " abort_idle"}, 32'(get_all()), 32'(IDLE_OUT));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        logic [11:0] a;
        vec_t v;

        tbl[0]  = mk(12'h008, 1'b1, 1'b0, 0,  1'b0, 6'b100000, 4'b0000, 5);
        tbl[1]  = mk(12'h010, 1'b0, 1'b0, 20, 1'b0, 6'b000000, 4'b1000, 5);
        tbl[2]  = mk(12'h03C, 1'b0, 1'b0, 20, 1'b0, 6'b000000, 4'b0100, 5);
        tbl[3]  = mk(12'h014, 1'b0, 1'b1, 0,  1'b0, 6'b000000, 4'b0000, 5);
        tbl[4]  = mk(12'h014, 1'b0, 1'b0, 0,  1'b0, 6'b000000, 4'b0001, 5);
        tbl[5]  = mk(12'h048, 1'b1, 1'b0, 0,  1'b0, 6'b000001, 4'b0000, 7);
        tbl[6]  = mk(12'h00C, 1'b1, 1'b0, 0,  1'b0, 6'b000000, 4'b0000, 5);
        tbl[7]  = mk(12'h00C, 1'b0, 1'b0, 0,  1'b0, 6'b000010, 4'b0000, 5);
        tbl[8]  = mk(12'h018, 1'b1, 1'b0, 0,  1'b0, 6'b000000, 4'b0010, 5);
        tbl[9]  = mk(12'h01C, 1'b1, 1'b0, 0,  1'b0, 6'b001000, 4'b0000, 5);
        tbl[10] = mk(12'h004, 1'b1, 1'b0, 0,  1'b1, 6'b000100, 4'b0000, 5);
        tbl[11] = mk(12'h108, 1'b1, 1'b0, 0,  1'b0, 6'b000000, 4'b0000, 5);
        tbl[12] = mk(12'h00B, 1'b0, 1'b1, 3,  1'b0, 6'b010000, 4'b0000, 5);

        bif.addr   = '0;
        bif.rw     = 1'b1;
        bif.dmadir = 1'b0;
        bif.as_n   = 1'b1;
        bif.dmac_n = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outputs", 32'(get_all()), 32'(IDLE_OUT));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_after_reset", 32'(get_all()), 32'(IDLE_OUT));

        for (int t = 0; t < 13; t++) run_cycle(tbl[t], $sformatf("vec%0d", t));

        // Address-map sweep: upper bits zero must decode, nonzero must not.
        for (int up = 0; up < 2; up++) begin
            for (int off = 0; off <= 'h7C; off += 4) begin
                for (int rw = 0; rw < 2; rw++) begin
                    a = 12'(off) | 12'($urandom_range(0, 3));
                    a[11:8] = (up == 0) ? 4'h0 : 4'(1 + $urandom_range(0, 14));
                    v = model(a, 1'(rw), 1'($urandom_range(0, 1)));
                    run_cycle(v, $sformatf("sweep_a%03h_rw%0d", a, rw));
                end
            end
        end

        abort_cycle(12'h010, 1'b0, 2, "abort_st");
        abort_cycle(12'h048, 1'b1, 3, "abort_wd");

        // Reset asserted while in ACK with a strobe active.
        @(negedge clk);
        bif.addr   = 12'h010;
        bif.rw     = 1'b0;
        bif.as_n   = 1'b0;
        bif.dmac_n = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bif.dsack_n == 1'b0) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) timeout_fail("rst_in_ack wait_ack");
        rst_n = 1'b0;
        #1;
        check("rst_in_ack outputs", 32'(get_all()), 32'(IDLE_OUT));
        bif.as_n   = 1'b1;
        bif.dmac_n = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_in_ack recovered", 32'(get_all()), 32'(IDLE_OUT));

        run_cycle(tbl[0], "post_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
